// File: rtl/imem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imem_ctrl_pkg
// Types and defaults for the CPU instruction-memory controller.
//   imem_state_e      : controller FSM states (IDLE, REQ, WAIT, FILL)
//   NOP_INSTR_DEFAULT : instruction word driven when nothing valid is present
// -----------------------------------------------------------------------------
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } imem_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/imem_ctrl_line_array.sv
// -----------------------------------------------------------------------------
// imem_line_array
// Tag/data/valid storage for a direct-mapped, one-word-per-line cache.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset (valid bits only)
//   clear_all           : clear every valid bit on the next edge
//   wr_en/wr_idx/wr_tag/wr_data : single write port; sets the line valid
//   rd_idx              : combinational read index
//   rd_valid/rd_tag/rd_data     : contents of line rd_idx (pre-write values
//                                 during a same-cycle write)
// -----------------------------------------------------------------------------
module imem_line_array #(
  parameter int LINES = 16,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_all,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data
);

  logic [LINES-1:0] valid_reg;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  // The fill write takes priority over a bulk clear for its own line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
    end else begin
      for (int i = 0; i < LINES; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          valid_reg[i] <= 1'b1;
        end else if (clear_all) begin
          valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Tag and data need no reset: a line is only trusted when its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_reg[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/imem_ctrl.sv
// -----------------------------------------------------------------------------
// imem_ctrl
// Instruction-fetch controller with a direct-mapped one-word-per-line cache.
// Hits return the line one cycle later; misses fetch one word from memory
// (REQ -> WAIT -> FILL) while stalling the pipeline.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   fetch_addr, fetch_en  : fetch byte address and its qualifier
//   flush                 : kill any in-flight fetch output
//   invalidate            : clear all line valid bits
//   instr, instr_valid    : fetched instruction and qualifier
//   imem_stall            : stall request to the hazard unit
//   mem_rd_*              : memory read request / grant / response
// -----------------------------------------------------------------------------
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int          LINES     = 16,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_en,
  input  logic        flush,
  input  logic        invalidate,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        imem_stall,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_gnt,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - IDX_W;

  imem_state_e state_reg, state_next;
  logic        kill_reg;
  logic [31:0] addr_reg;
  logic [31:0] data_reg;
  logic        hit_valid_reg;
  logic [31:0] hit_data_reg;

  logic             line_valid;
  logic [TAG_W-1:0] line_tag;
  logic [31:0]      line_data;
  logic             lookup;
  logic             hit;
  logic             capture;
  logic             stall;
  logic             fill_kill;

  imem_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_lines (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_all (invalidate),
    .wr_en     (state_reg == ST_FILL),
    .wr_idx    (addr_reg[IDX_W+1:2]),
    .wr_tag    (addr_reg[31:IDX_W+2]),
    .wr_data   (data_reg),
    .rd_idx    (fetch_addr[IDX_W+1:2]),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_data)
  );

  assign lookup = (state_reg == ST_IDLE) && fetch_en;
  assign hit    = line_valid && (line_tag == fetch_addr[31:IDX_W+2]);

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    stall      = 1'b0;
    mem_rd_req = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (fetch_en && !hit) begin
          stall      = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        stall      = 1'b1;
        mem_rd_req = 1'b1;
        if (mem_rd_gnt) begin
          capture    = mem_rd_valid;
          state_next = mem_rd_valid ? ST_FILL : ST_WAIT;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (mem_rd_valid) begin
          capture    = 1'b1;
          state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Stall is forced low while reset is asserted, even with a pending miss.
  assign imem_stall  = rst_n && stall;
  assign mem_rd_addr = addr_reg;

  // A flush arriving in the FILL cycle itself also kills that cycle's output.
  assign fill_kill = kill_reg || flush;

  always_comb begin
    instr       = NOP_INSTR;
    instr_valid = 1'b0;
    if (state_reg == ST_FILL) begin
      if (!fill_kill) begin
        instr       = data_reg;
        instr_valid = 1'b1;
      end
    end else if (hit_valid_reg) begin
      instr       = hit_data_reg;
      instr_valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      kill_reg      <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      hit_valid_reg <= 1'b0;
      hit_data_reg  <= NOP_INSTR;
    end else begin
      state_reg <= state_next;

      if (state_reg == ST_FILL) begin
        kill_reg <= 1'b0;
      end else if (flush && (state_reg != ST_IDLE)) begin
        kill_reg <= 1'b1;
      end

      if (lookup && !hit) begin
        addr_reg <= fetch_addr & 32'hFFFF_FFFC;
      end

      if (capture) begin
        data_reg <= mem_rd_data;
      end

      hit_valid_reg <= lookup && hit && !flush;
      if (lookup && hit) begin
        hit_data_reg <= line_data;
      end
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_ctrl
// Self-checking bench for imem_ctrl (LINES=16). A transaction-level cache model
// (valid/tag/data arrays indexed by address arithmetic) decides hit or miss and
// the expected instruction; the bench plays memory with chosen grant/response
// delays and checks every cycle's outputs.
// -----------------------------------------------------------------------------
module tb_imem_ctrl;

  localparam int          LINES = 16;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_addr;
  logic        fetch_en;
  logic        flush;
  logic        invalidate;
  logic [31:0] instr;
  logic        instr_valid;
  logic        imem_stall;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_gnt;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;

  int checks   = 0;
  int failures = 0;

  // Reference cache contents
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  logic [31:0] m_data  [LINES];

  imem_ctrl #(
    .LINES     (LINES),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_addr   (fetch_addr),
    .fetch_en     (fetch_en),
    .flush        (flush),
    .invalidate   (invalidate),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .imem_stall   (imem_stall),
    .mem_rd_req   (mem_rd_req),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_gnt   (mem_rd_gnt),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_data  (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % LINES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (4 * LINES);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // All tasks start and end at a falling edge.
  task automatic idle_cycle(input bit inv);
    fetch_en   = 1'b0;
    invalidate = inv;
    #1;
    check_val("idle_stall", 32'(imem_stall), 32'd0);
    @(posedge clk);
    if (inv) model_clear();
    @(negedge clk);
    invalidate = 1'b0;
    #1;
    check_val("idle_valid", 32'(instr_valid), 32'd0);
    check_val("idle_instr", instr, NOP);
  endtask

  // One fetch. On a miss: g extra REQ cycles before grant, w WAIT cycles
  // (0 = data with grant), flush_at = cycle index after issue (-1 none),
  // inv_fill = invalidate during the FILL cycle.
  task automatic do_fetch(input logic [31:0] addr, input bit fl_idle, input bit inv_issue,
                          input int g, input int w, input int flush_at,
                          input bit inv_fill, input logic [31:0] mdata);
    logic [31:0] aligned;
    logic [31:0] hdata;
    bit          is_hit;
    bit          killed;
    int          n;
    aligned = addr & 32'hFFFF_FFFC;
    is_hit  = model_hit(addr);
    hdata   = m_data[idx_of(addr)];
    killed  = 1'b0;
    n       = 0;
    fetch_en   = 1'b1;
    fetch_addr = addr;
    flush      = fl_idle;
    invalidate = inv_issue;
    #1;
    if (is_hit) begin
      check_val("hit_stall", 32'(imem_stall), 32'd0);
      check_val("hit_req", 32'(mem_rd_req), 32'd0);
      @(posedge clk);
      if (inv_issue) model_clear();
      @(negedge clk);
      fetch_en = 1'b0; flush = 1'b0; invalidate = 1'b0;
      #1;
      check_val("hit_valid", 32'(instr_valid), fl_idle ? 32'd0 : 32'd1);
      check_val("hit_instr", instr, fl_idle ? NOP : hdata);
      $display("fetch %h hit  flush=%0d instr=%h valid=%0d", addr, fl_idle, instr, instr_valid);
    end else begin
      check_val("miss_stall", 32'(imem_stall), 32'd1);
      @(posedge clk);
      if (inv_issue) model_clear();
      for (int k = 0; k <= g; k++) begin
        @(negedge clk);
        fetch_en = 1'b0; invalidate = 1'b0;
        mem_rd_gnt   = (k == g);
        mem_rd_valid = (k == g) && (w == 0);
        mem_rd_data  = mem_rd_valid ? mdata : $urandom;
        flush        = (n == flush_at);
        if (flush) killed = 1'b1;
        #1;
        check_val("req_req", 32'(mem_rd_req), 32'd1);
        check_val("req_addr", mem_rd_addr, aligned);
        check_val("req_stall", 32'(imem_stall), 32'd1);
        check_val("req_valid", 32'(instr_valid), 32'd0);
        @(posedge clk);
        n++;
      end
      for (int k = 1; k <= w; k++) begin
        @(negedge clk);
        mem_rd_gnt   = 1'b0;
        mem_rd_valid = (k == w);
        mem_rd_data  = mem_rd_valid ? mdata : $urandom;
        flush        = (n == flush_at);
        if (flush) killed = 1'b1;
        #1;
        check_val("wait_req", 32'(mem_rd_req), 32'd0);
        check_val("wait_stall", 32'(imem_stall), 32'd1);
        check_val("wait_valid", 32'(instr_valid), 32'd0);
        @(posedge clk);
        n++;
      end
      @(negedge clk);
      mem_rd_gnt   = 1'b0;
      mem_rd_valid = 1'b0;
      mem_rd_data  = $urandom;
      flush        = (n == flush_at);
      if (flush) killed = 1'b1;
      invalidate   = inv_fill;
      #1;
      check_val("fill_stall", 32'(imem_stall), 32'd0);
      check_val("fill_req", 32'(mem_rd_req), 32'd0);
      check_val("fill_valid", 32'(instr_valid), killed ? 32'd0 : 32'd1);
      check_val("fill_instr", instr, killed ? NOP : mdata);
      $display("fetch %h miss g=%0d w=%0d kill=%0d inv_fill=%0d instr=%h valid=%0d",
               addr, g, w, killed, inv_fill, instr, instr_valid);
      @(posedge clk);
      if (inv_fill) model_clear();
      m_valid[idx_of(addr)] = 1'b1;
      m_tag[idx_of(addr)]   = tag_of(addr);
      m_data[idx_of(addr)]  = mdata;
      @(negedge clk);
      flush = 1'b0; invalidate = 1'b0;
      #1;
      check_val("post_fill_valid", 32'(instr_valid), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_addr = '0; fetch_en = 1'b0; flush = 1'b0; invalidate = 1'b0;
    mem_rd_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_valid", 32'(instr_valid), 32'd0);
    check_val("rst_instr", instr, NOP);
    check_val("rst_req", 32'(mem_rd_req), 32'd0);
    check_val("rst_addr", mem_rd_addr, 32'd0);
    check_val("rst_stall", 32'(imem_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle(1'b0);

    // Cold miss at 0x100, then a hit, then an aliasing tag evicts it
    do_fetch(32'h100, 0, 0, 1, 3, -1, 0, 32'h2001_0005);
    do_fetch(32'h100, 0, 0, 0, 0, -1, 0, 32'h0);
    do_fetch(32'h140, 0, 0, 0, 1, -1, 0, 32'h1111_2222);
    do_fetch(32'h100, 0, 0, 2, 0, -1, 0, 32'h2001_0005);
    // Flush during WAIT: memory handshake completes, output killed, line fills
    do_fetch(32'h200, 0, 0, 1, 3, 2, 0, 32'h3333_4444);
    do_fetch(32'h202, 0, 0, 0, 0, -1, 0, 32'h0);
    // Flush with a hit suppresses the output
    do_fetch(32'h200, 1, 0, 0, 0, -1, 0, 32'h0);
    // Invalidate then refetch misses
    idle_cycle(1'b1);
    do_fetch(32'h100, 0, 0, 0, 2, -1, 0, 32'h5555_6666);
    // Invalidate coinciding with a fill: only the filled line survives
    do_fetch(32'h104, 0, 0, 0, 0, -1, 0, 32'h7777_8888);
    do_fetch(32'h108, 0, 0, 0, 1, -1, 1, 32'h9999_AAAA);
    do_fetch(32'h108, 0, 0, 0, 0, -1, 0, 32'h0);
    do_fetch(32'h104, 0, 0, 1, 1, -1, 0, 32'h7777_8889);

    // Reset asserted while waiting for data
    idle_cycle(1'b1);
    fetch_en = 1'b1; fetch_addr = 32'h300;
    @(posedge clk);
    @(negedge clk);
    fetch_en = 1'b0; mem_rd_gnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_rd_gnt = 1'b0;
    fetch_en = 1'b1;
    rst_n = 1'b0;
    #1;
    check_val("arst_valid", 32'(instr_valid), 32'd0);
    check_val("arst_instr", instr, NOP);
    check_val("arst_req", 32'(mem_rd_req), 32'd0);
    check_val("arst_addr", mem_rd_addr, 32'd0);
    check_val("arst_stall", 32'(imem_stall), 32'd0);
    $display("reset in WAIT req=%0d addr=%h stall=%0d", mem_rd_req, mem_rd_addr, imem_stall);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1; fetch_en = 1'b0;
    mem_rd_valid = 1'b1; mem_rd_data = 32'hDEAD_BEEF;
    #1;
    check_val("late_req", 32'(mem_rd_req), 32'd0);
    @(negedge clk);
    mem_rd_valid = 1'b0;
    #1;
    check_val("late_valid", 32'(instr_valid), 32'd0);
    check_val("late_stall", 32'(imem_stall), 32'd0);
    do_fetch(32'h300, 0, 0, 0, 0, -1, 0, 32'hCAFE_0300);

    // Randomized traffic over a small address pool to mix hits and misses
    for (int it = 0; it < 150; it++) begin
      logic [31:0] a;
      int g, w, fa;
      bit fl, inv, invf;
      a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
        | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) begin
        idle_cycle($urandom_range(0, 9) == 0);
      end else begin
        g    = $urandom_range(0, 3);
        w    = $urandom_range(0, 3);
        fa   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, g + 1 + w) : -1;
        fl   = model_hit(a) && ($urandom_range(0, 4) == 0);
        inv  = ($urandom_range(0, 11) == 0);
        invf = ($urandom_range(0, 7) == 0);
        do_fetch(a, fl, inv, g, w, fa, invf, $urandom);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 Parameter LINES, default 16, SHALL set the number of direct-mapped one-word cache lines (power of two, 2..256).
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, SHALL be the value driven on instr when no valid instruction is present.
REQ-003 Clocking SHALL use one clock; reset is asynchronous and active-low: clk input 1, rst_n input 1.
REQ-004 Port fetch_addr, input, 32 bits, SHALL carry the fetch byte address (next PC) from the fetch stage.
REQ-005 Port fetch_en, input, 1 bit, SHALL indicate that fetch_addr is valid this cycle.
REQ-006 Port flush, input, 1 bit, SHALL be the hazard-unit flush that kills any in-flight fetch.
REQ-007 Port invalidate, input, 1 bit, SHALL clear all line valid bits.
REQ-008 Port instr, output, 32 bits, SHALL carry the fetched instruction word.
REQ-009 Port instr_valid, output, 1 bit, SHALL qualify instr.
REQ-010 Port imem_stall, output, 1 bit, SHALL be the stall request to the hazard unit.
REQ-011 Memory read ports SHALL be: mem_rd_req output 1; mem_rd_addr output 32; mem_rd_gnt input 1; mem_rd_valid input 1; mem_rd_data input 32.

Function
REQ-012 Index SHALL be fetch_addr[log2(LINES)+1:2], tag SHALL be fetch_addr[31:log2(LINES)+2], and bits [1:0] SHALL be ignored.
REQ-013 On a hit (IDLE, fetch_en, line valid, tag equal), the line data SHALL appear on instr with instr_valid=1 exactly one cycle later (registered).
REQ-014 FSM states SHALL be IDLE, REQ, WAIT, FILL.
REQ-015 IDLE transitions: a miss with fetch_en=1 SHALL latch the word-aligned address and go to REQ; otherwise the FSM SHALL stay in IDLE.
REQ-016 In REQ, mem_rd_req=1 and mem_rd_addr=latched address SHALL be held stable until mem_rd_gnt=1; on grant the FSM SHALL go to WAIT, or to FILL if mem_rd_valid is also 1 in the same cycle.
REQ-017 In WAIT, the FSM SHALL remain until mem_rd_valid=1, then capture mem_rd_data and go to FILL.
REQ-018 In FILL, the captured word SHALL be written to the line (valid=1, tag updated), instr=word with instr_valid=1 SHALL be driven for one cycle, and the FSM SHALL return to IDLE.
REQ-019 imem_stall SHALL be 1 combinationally when (IDLE and fetch_en and miss), or when in REQ or WAIT; it SHALL be 0 in FILL and on hits.
REQ-020 instr_valid SHALL be 0 and instr SHALL be NOP_INSTR whenever no hit or FILL output occurs.
REQ-021 flush in IDLE SHALL suppress the next-cycle hit output.
REQ-022 flush in REQ, WAIT or FILL SHALL set a kill flag: the transaction SHALL complete and the line SHALL still fill, but FILL SHALL drive instr_valid=0, and the kill flag SHALL clear on return to IDLE.
REQ-023 mem_rd_req SHALL never be withdrawn before grant, including on flush.
REQ-024 invalidate SHALL clear all valid bits on the next edge; if it coincides with FILL, the fill write SHALL win for that line.
REQ-025 A read-during-fill to the same index SHALL see the old contents; the new data SHALL be visible from the following cycle.

Reset
REQ-026 rst_n low SHALL asynchronously force: FSM=IDLE, all valid bits=0, kill=0, instr=NOP_INSTR, instr_valid=0, mem_rd_req=0, mem_rd_addr=0, imem_stall=0.
REQ-027 Reset mid-transaction SHALL abandon it; a late mem_rd_valid after reset SHALL be ignored in IDLE.
REQ-028 The data array SHALL NOT require reset.

Structure
REQ-029 The FSM state enum and the NOP_INSTR default SHALL reside in the shared CPU package.
REQ-030 The tag/data/valid storage SHALL be a sub-module imem_line_array (one write port, one combinational read port, bulk valid clear).

Verification
REQ-031 After reset, fetch 0x100 with gnt after 2 cycles and valid 3 cycles later, data 0x2001_0005 -> imem_stall high 6 cycles; instr=0x2001_0005, instr_valid=1 in FILL; line filled.
REQ-032 Refetch 0x100 -> instr=0x2001_0005 one cycle later, imem_stall=0, no mem_rd_req.
REQ-033 Fetch 0x140 (LINES=16, same index as 0x100, different tag) -> miss, refill, and subsequent 0x100 misses again.
REQ-034 Flush asserted while in WAIT for 0x200 -> mem_rd_req held until gnt, FILL drives instr_valid=0, and a later fetch of 0x200 hits.
REQ-035 invalidate after filling 0x100 -> next fetch of 0x100 misses and issues mem_rd_addr=0x100.
REQ-036 rst_n pulsed low in WAIT -> all outputs at reset values immediately, and a late mem_rd_valid is ignored.
